i2c_target_expander: RTL and testbench

- I2C target (slave) that emulates an 8-bit PCF8574-style port expander.
- It is the responding end of the bus that our I2C master and the LCD driver initiate on.
- It lets the LCD backpack path run in loopback, on-board and in simulation, without the physical expander.
- Write bytes are latched onto an 8-bit output port. Read transfers return an 8-bit input port.

---
 rtl/i2c_target_expander.sv | 258 +++++++++++++++++++++++++
 tb/tb_i2c_target_expander.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_expander.sv
// I2C target emulating a PCF8574-style 8-bit port expander: writes land on port_out,
// reads return port_in. Open-drain sda via sda_oe; scl is never stretched.
module i2c_target_expander #(
    parameter logic [6:0]  DEV_ADDR    = 7'h27,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] port_in,
    output logic [7:0] port_out,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       addressed,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrite,
        StWriteAck,
        StRead,
        StReadAck,
        StIgnore
    } state_e;

    // Synchronisers reset to 1 so an idle bus produces no spurious edges.
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_prev, sda_prev;
    logic                   scl_s, sda_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    logic scl_rise, scl_fall, start_c, stop_c;

    assign scl_rise = scl_s & ~scl_prev;
    assign scl_fall = ~scl_s & scl_prev;
    // Requiring scl high on both samples keeps a simultaneous scl/sda change from
    // being taken as a bus condition.
    assign start_c  = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_c   = scl_s & scl_prev & ~sda_prev & sda_s;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic       phase_q, phase_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] port_out_q, port_out_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       addressed_q, addressed_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            port_out_q  <= 8'hFF;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            addressed_q <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            phase_q     <= phase_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            port_out_q  <= port_out_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            addressed_q <= addressed_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
        end
    end

    // phase_q marks the second half of an ACK slot (ACK driven, or master ACK seen).
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        phase_d     = phase_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        port_out_d  = port_out_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        addressed_d = addressed_q;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;

        if (start_c) begin
            state_d     = StAddr;
            bit_cnt_d   = 4'd0;
            phase_d     = 1'b0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            start_det_d = 1'b1;
        end else if (stop_c) begin
            state_d     = StIdle;
            bit_cnt_d   = 4'd0;
            phase_d     = 1'b0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            stop_det_d  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sda_oe_d = 1'b0;
                end
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            rw_d      = sda_s;
                            phase_d   = 1'b0;
                            // Address 0 is the general call and is never acknowledged.
                            if (shift_q[6:0] == DEV_ADDR && DEV_ADDR != 7'd0) begin
                                state_d = StAddrAck;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d    = 1'b1;
                            addressed_d = 1'b1;
                            phase_d     = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (rw_q) begin
                                state_d   = StRead;
                                tx_d      = port_in;
                                sda_oe_d  = ~port_in[7];
                                bit_cnt_d = 4'd1;
                            end else begin
                                state_d  = StWrite;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                StWrite: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            port_out_d = {shift_q[6:0], sda_s};
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = 4'd0;
                            phase_d    = 1'b0;
                            state_d    = StWriteAck;
                        end
                    end
                end
                StWriteAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = StWrite;
                        end
                    end
                end
                StRead: begin
                    // tx_q[7] is the bit on the bus; bit_cnt_q counts bits presented.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                            state_d   = StReadAck;
                        end else begin
                            sda_oe_d  = ~tx_q[6];
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StReadAck: begin
                    if (!phase_q && scl_rise) begin
                        if (sda_s) begin
                            addressed_d = 1'b0;
                            state_d     = StIgnore;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (phase_q && scl_fall) begin
                        tx_d      = port_in;
                        sda_oe_d  = ~port_in[7];
                        bit_cnt_d = 4'd1;
                        phase_d   = 1'b0;
                        state_d   = StRead;
                    end
                end
                StIgnore: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign port_out  = port_out_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign addressed = addressed_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_target_expander.sv
// Directed bench for i2c_target_expander: a bit-banged master on a wired-AND sda line.
`timescale 1ns/1ps
module tb_i2c_target_expander;

    localparam int Q = 200;  // quarter scl period in ns

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] port_in = 8'h00;
    logic [7:0] port_out;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       addressed;
    logic       start_det;
    logic       stop_det;

    assign sda_in = sda_m & ~sda_oe;

    i2c_target_expander #(
        .DEV_ADDR   (7'h27),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .port_in  (port_in),
        .port_out (port_out),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .addressed(addressed),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    always #5 clk = ~clk;

    int unsigned rx_cnt = 0, oe_cnt = 0, addr_cnt = 0, start_cnt = 0, stop_cnt = 0;
    logic [7:0]  rx_log [64];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[5:0]] = rx_data;
            rx_cnt++;
        end
        if (sda_oe) oe_cnt++;
        if (addressed) addr_cnt++;
        if (start_det) start_cnt++;
        if (stop_det) stop_cnt++;
    end

    int n_total = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl = 1'b1;   #Q;
        sda_m = 1'b0; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl = 1'b1;   #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl = 1'b1;   #Q;
        b = sda_in;   #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        ack;
        logic [7:0]  rd;
        logic [7:0]  mw [4];
        int unsigned s_rx, s_oe, s_addr, s_start, s_stop;

        // Reset state
        #23;
        check("rst_sda_oe", sda_oe, 0);
        check("rst_port_out", port_out, 8'hFF);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_addressed", addressed, 0);
        check("rst_start_det", start_det, 0);
        check("rst_stop_det", stop_det, 0);
        reset = 1'b1;
        #100;

        // Wrong address: never acknowledged, nothing latched
        s_rx = rx_cnt; s_oe = oe_cnt; s_addr = addr_cnt; s_start = start_cnt; s_stop = stop_cnt;
        i2c_start();
        write_byte(8'h40, ack); check("wa_addr_nack", ack, 1);
        write_byte(8'h55, ack); check("wa_data_nack", ack, 1);
        i2c_stop(); #Q;
        check("wa_oe_never", oe_cnt - s_oe, 0);
        check("wa_port_out", port_out, 8'hFF);
        check("wa_no_rx", rx_cnt - s_rx, 0);
        check("wa_not_addressed", addr_cnt - s_addr, 0);
        check("wa_start_det", start_cnt - s_start, 1);
        check("wa_stop_det", stop_cnt - s_stop, 1);

        // Single-byte write
        s_rx = rx_cnt; s_stop = stop_cnt;
        i2c_start();
        write_byte(8'h4E, ack); check("w1_addr_ack", ack, 0);
        check("w1_addressed", addressed, 1);
        write_byte(8'h08, ack); check("w1_data_ack", ack, 0);
        i2c_stop(); #Q;
        check("w1_port_out", port_out, 8'h08);
        check("w1_rx_count", rx_cnt - s_rx, 1);
        check("w1_rx_log", rx_log[s_rx[5:0]], 8'h08);
        check("w1_rx_data", rx_data, 8'h08);
        check("w1_stop_det", stop_cnt - s_stop, 1);
        check("w1_addressed_after_stop", addressed, 0);

        // Read with master NACK
        port_in = 8'hA5;
        i2c_start();
        write_byte(8'h4F, ack); check("rd_addr_ack", ack, 0);
        read_byte(rd, 1'b1);
        check("rd_byte", rd, 8'hA5);
        check("rd_addressed_after_nack", addressed, 0);
        s_oe = oe_cnt;
        i2c_stop(); #Q;
        check("rd_oe_after_nack", oe_cnt - s_oe, 0);

        // Multi-byte write
        mw[0] = 8'h4E; mw[1] = 8'h33; mw[2] = 8'h32; mw[3] = 8'h28;
        s_rx = rx_cnt;
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(mw[i], ack);
            check($sformatf("mw_ack%0d", i), ack, 0);
        end
        i2c_stop(); #Q;
        check("mw_rx_count", rx_cnt - s_rx, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mw_rx%0d", i), rx_log[6'(s_rx + i)], mw[i+1]);
        end
        check("mw_port_out", port_out, 8'h28);

        // Repeated START: write then read twice
        port_in = 8'h3C;
        s_start = start_cnt;
        i2c_start();
        write_byte(8'h4E, ack); check("rs_waddr_ack", ack, 0);
        write_byte(8'h0C, ack); check("rs_wdata_ack", ack, 0);
        i2c_start();
        write_byte(8'h4F, ack); check("rs_raddr_ack", ack, 0);
        read_byte(rd, 1'b0); check("rs_read0", rd, 8'h3C);
        read_byte(rd, 1'b1); check("rs_read1", rd, 8'h3C);
        i2c_stop(); #Q;
        check("rs_start_det", start_cnt - s_start, 2);
        check("rs_port_out", port_out, 8'h0C);

        // Reset while the target drives a 0 data bit
        port_in = 8'h00;
        i2c_start();
        write_byte(8'h4F, ack); check("rr_addr_ack", ack, 0);
        check("rr_driving", sda_oe, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rr_oe_released", sda_oe, 0);
        check("rr_port_out", port_out, 8'hFF);
        #50;
        reset = 1'b1;
        #Q;
        i2c_stop(); #Q;
        i2c_start();
        write_byte(8'h4E, ack); check("rr_post_addr_ack", ack, 0);
        write_byte(8'h5A, ack); check("rr_post_data_ack", ack, 0);
        i2c_stop(); #Q;
        check("rr_post_port_out", port_out, 8'h5A);

        // STOP in mid-byte discards the partial bits
        s_rx = rx_cnt;
        i2c_start();
        write_byte(8'h4E, ack); check("ab_addr_ack", ack, 0);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop(); #Q;
        check("ab_port_out", port_out, 8'h5A);
        check("ab_no_rx", rx_cnt - s_rx, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
